// File: rtl/cargador_instrucciones_if.sv
// Byte-stream, instruction-memory write and core-control signals between a program source and the loader.
interface cargador_instrucciones_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        dato_in;
    logic              valido_in;
    logic              listo_out;
    logic              recargar;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_dir;
    logic [31:0]       mem_dato;
    logic              reset_cpu;
    logic              cargado;
    logic              error;
    logic [15:0]       palabras;

    modport master (
        output dato_in, valido_in, recargar,
        input  listo_out, mem_we, mem_dir, mem_dato, reset_cpu, cargado, error, palabras
    );

    modport slave (
        input  dato_in, valido_in, recargar,
        output listo_out, mem_we, mem_dir, mem_dato, reset_cpu, cargado, error, palabras
    );
endinterface

// File: rtl/cargador_instrucciones.sv
// Loads length + little-endian words + XOR checksum into instruction memory; one write the cycle after each word's last byte.
// listo_out follows state only: bytes stream back-to-back while loading, none accepted in DONE/ERROR.
module cargador_instrucciones #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                     clk_RV,
    input  logic                     reset,
    cargador_instrucciones_if.slave  bus
);
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} estado_t;

    localparam logic [LEN_W:0] CAPACIDAD = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    estado_t           estado_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  palabras_q;
    logic [7:0]        csum_q;
    logic [1:0]        idx_q;
    logic [23:0]       bytes_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_dir_q;
    logic [31:0]       mem_dato_q;
    logic              reset_cpu_q;
    logic              cargado_q;
    logic              error_q;

    logic              listo;
    logic              acepta;
    logic [LEN_W-1:0]  len_d;
    logic [LEN_W-1:0]  palabras_d;

    assign listo      = (estado_q == LEN_LO) || (estado_q == LEN_HI) ||
                        (estado_q == DATA)   || (estado_q == CHECK);
    assign acepta     = bus.valido_in && listo;
    assign len_d      = {bus.dato_in, len_q[7:0]};
    assign palabras_d = palabras_q + LEN_W'(1);

    always_ff @(posedge clk_RV or negedge reset) begin
        if (!reset) begin
            estado_q    <= LEN_LO;
            len_q       <= '0;
            palabras_q  <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            bytes_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_dir_q   <= '0;
            mem_dato_q  <= '0;
            reset_cpu_q <= 1'b1;
            cargado_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (estado_q)
                LEN_LO: if (acepta) begin
                    len_q[7:0] <= bus.dato_in;
                    csum_q     <= csum_q ^ bus.dato_in;
                    estado_q   <= LEN_HI;
                end
                LEN_HI: if (acepta) begin
                    len_q  <= len_d;
                    csum_q <= csum_q ^ bus.dato_in;
                    // A full memory (N == capacity) is legal; anything larger would wrap.
                    if ({1'b0, len_d} > CAPACIDAD) begin
                        estado_q <= ERROR;
                        error_q  <= 1'b1;
                    end else if (len_d == '0) begin
                        estado_q <= CHECK;
                    end else begin
                        estado_q <= DATA;
                    end
                end
                DATA: if (acepta) begin
                    csum_q <= csum_q ^ bus.dato_in;
                    idx_q  <= idx_q + 2'd1;
                    case (idx_q)
                        2'd0: bytes_q[7:0]   <= bus.dato_in;
                        2'd1: bytes_q[15:8]  <= bus.dato_in;
                        2'd2: bytes_q[23:16] <= bus.dato_in;
                        default: begin
                            mem_we_q   <= 1'b1;
                            mem_dato_q <= {bus.dato_in, bytes_q};
                            mem_dir_q  <= palabras_q[ADDR_W-1:0];
                            palabras_q <= palabras_d;
                            if (palabras_d == len_q) estado_q <= CHECK;
                        end
                    endcase
                end
                CHECK: if (acepta) begin
                    if (bus.dato_in == csum_q) begin
                        estado_q    <= DONE;
                        cargado_q   <= 1'b1;
                        reset_cpu_q <= 1'b0;
                    end else begin
                        estado_q <= ERROR;
                        error_q  <= 1'b1;
                    end
                end
                DONE, ERROR: if (bus.recargar) begin
                    estado_q    <= LEN_LO;
                    reset_cpu_q <= 1'b1;
                    cargado_q   <= 1'b0;
                    error_q     <= 1'b0;
                    palabras_q  <= '0;
                    csum_q      <= '0;
                    idx_q       <= '0;
                end
                default: begin
                    estado_q <= ERROR;
                    error_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.listo_out = listo;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_dir   = mem_dir_q;
    assign bus.mem_dato  = mem_dato_q;
    assign bus.reset_cpu = reset_cpu_q;
    assign bus.cargado   = cargado_q;
    assign bus.error     = error_q;
    assign bus.palabras  = palabras_q;
endmodule

// File: doc/cargador_instrucciones.md
Name: cargador_instrucciones

Overview:
- Program loader that sits directly upstream of the rv32i core's instruction memory.
- Receives a byte stream (length header, instruction words, checksum) over a valid/ready handshake and writes 32-bit little-endian words into the instruction memory write port.
- Holds the core in reset until a complete, checksum-valid program has been written. The core is released on success only.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address; capacity is 2^ADDR_W words.
- LEN_W, 16, width of the length header and of the word counter (fixed at 16; the header is 2 bytes).

Ports:
- clk_RV  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- dato_in  input  8  incoming stream byte.
- valido_in  input  1  dato_in is valid this cycle.
- listo_out  output  1  loader can accept a byte this cycle.
- recargar  input  1  single-cycle request to start a new load from DONE or ERROR.
- mem_we  output  1  instruction-memory write enable.
- mem_dir  output  ADDR_W  word address for the write.
- mem_dato  output  32  word to write.
- reset_cpu  output  1  active-high reset to the rv32i core.
- cargado  output  1  program loaded and verified.
- error  output  1  load failed (overflow or checksum).
- palabras  output  16  number of words written in the current load.

Behaviour:
- Reset values (reset=0, asynchronous): state LEN_LO, listo_out=1, mem_we=0, mem_dir=0, mem_dato=0, reset_cpu=1, cargado=0, error=0, palabras=0, internal checksum=0, byte index=0.
- A byte is accepted on a rising edge with valido_in=1 and listo_out=1. listo_out is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERROR.
- Running checksum: XOR of every accepted byte except the final checksum byte.
- State LEN_LO:
  - The accepted byte becomes N[7:0].
  - Go to LEN_HI.
- State LEN_HI:
  - The accepted byte becomes N[15:8].
  - If N > 2^ADDR_W, go to ERROR.
  - Else if N == 0, go to CHECK.
  - Else go to DATA.
- State DATA:
  - Bytes are accepted in order b0..b3 (byte index 0..3).
  - On acceptance of b3:
    - Next cycle: mem_we=1 for exactly one cycle, mem_dato={b3,b2,b1,b0}, mem_dir=palabras[ADDR_W-1:0] (pre-increment value).
    - palabras increments in the same cycle mem_we is high.
  - When the Nth word's b3 is accepted, go to CHECK.
  - listo_out stays 1 throughout, so back-to-back bytes give at most one write per 4 cycles.
- State CHECK:
  - The accepted byte is compared with the running checksum.
  - Equal: go to DONE.
  - Unequal: go to ERROR.
- State DONE:
  - cargado=1 and reset_cpu=0, both registered and valid the cycle after DONE is entered.
  - The final word's write has already completed before the checksum byte can arrive.
- State ERROR:
  - error=1 and reset_cpu stays 1.
  - mem_we is never asserted after ERROR is entered.
- recargar:
  - In DONE or ERROR, a rising edge with recargar=1 moves to LEN_LO. On the same edge: reset_cpu=1, cargado=0, error=0, palabras=0, checksum=0, byte index=0.
  - Memory contents are not cleared.
  - recargar is ignored in all other states.
- Simultaneous events:
  - valido_in together with listo_out=0 is a no-op; no byte is consumed.
  - recargar with valido_in=1 in DONE or ERROR: the byte is ignored, since listo_out=0 that cycle.
- Reset mid-load (asserted in any state): immediate return to reset values and reset_cpu=1. A pending mem_we is cancelled; partially written memory is not cleaned up.
- Address rule: N == 2^ADDR_W is legal and the last address is 2^ADDR_W-1. No wrap-around can occur, because N > 2^ADDR_W is rejected in LEN_HI.

Test Plan:
- Nominal: stream 02 00, 13 05 A0 00, 93 05 10 00, checksum (XOR of all ten bytes).
  - Two writes: addr0=0x00A00513, addr1=0x00100593.
  - palabras=2, cargado=1, reset_cpu falls 1 cycle after the checksum byte.
- Bad checksum: the same stream with the last byte XOR 0x01.
  - Both writes occur, then error=1, cargado=0, reset_cpu stays 1.
- Overflow (ADDR_W=8): header 01 01 (N=257).
  - ERROR after the second byte, zero mem_we pulses, listo_out=0.
- Zero length: 00 00 00.
  - Enters DONE with palabras=0, no writes, reset_cpu=0.
- Throttled input and mid-load reset:
  - valido_in toggling every other cycle still yields the correct word.
  - reset pulsed low after 6 data bytes gives all outputs at reset values; a full reload then succeeds.
- Reload: from DONE, pulse recargar, then load one word 0xDEADBEEF.
  - reset_cpu goes to 1 on the recargar edge.
  - addr0 is rewritten, cargado=1 again.
